store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the EX/MEM pipeline register and the word-addressed data memory. It accepts `sw` requests from the MEM stage in one cycle and retires them to memory in order, one per cycle, whenever the memory port is not needed by a load. `lw` requests pass straight through to the memory port with combinational read data. A load whose word address matches a pending store is resolved by stalling until that store drains, or by forwarding the buffered data when forwarding is compiled in.

## Interface
Parameters:
- `DEPTH`, 4: number of buffered stores; power of two, ≥2.
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width.

Ports:
- `clk_i`, input, 1: clock, rising edge.
- `rst_n_i`, input, 1: reset, asynchronous, active-low.
- `MemRead_i`, input, 1: load request from MEM stage.
- `MemWrite_i`, input, 1: store request from MEM stage.
- `addr_i`, input, ADDR_W: byte address; bits [1:0] ignored.
- `data_i`, input, DATA_W: store data.
- `data_o`, output, DATA_W: load result, combinational.
- `stall_o`, output, 1: MEM stage must hold its request this cycle.
- `empty_o`, output, 1: no pending stores.
- `mem_addr_o`, output, ADDR_W: address to data memory.
- `mem_data_o`, output, DATA_W: write data to data memory.
- `mem_MemRead_o`, output, 1: memory read enable.
- `mem_MemWrite_o`, output, 1: memory write enable.
- `mem_data_i`, input, DATA_W: memory read data, combinational.

## Operation
- **State:** circular FIFO of {word address `addr[ADDR_W-1:2]`, data}, plus head and tail pointers and a count.
- **Pointer arithmetic:** pointers wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits wide.
- **Full:** count == DEPTH.
- **Store acceptance:** a store is accepted when `MemWrite_i` is high and the buffer is not full. It is pushed at the clock edge.
- **Store stall:** when `MemWrite_i` is high and the buffer is full, `stall_o` is 1 and nothing is pushed. A pop in the same cycle does not unblock the store; it is accepted the following cycle.
- **Load issue:** a load issues when `MemRead_i` is high and there is no address hazard. In that case `mem_MemRead_o` is 1, `mem_addr_o` = `addr_i`, and `data_o` = `mem_data_i`.
- **Drain:** the buffer drains when count > 0 and no load is issued that cycle. In that case `mem_MemWrite_o` is 1, `mem_addr_o` = {head address, 2'b00}, and `mem_data_o` = head data. The head entry pops at the clock edge.
- **Port priority:** loads own the memory port. Stores retire only on cycles with no issued load.
- **Simultaneous push and pop:** count is unchanged.
- **Simultaneous `MemRead_i` and `MemWrite_i`:** both are handled. The load uses the port and the store is pushed, because pushing does not use the port.
- **Idle outputs:** with no load, `data_o` = 0. With no drain, `mem_MemWrite_o` = 0 and `mem_data_o` = 0.
- **Reset:** head, tail and count are cleared, so pending stores are discarded, including on reset mid-operation. Combinational outputs settle as follows: `stall_o` 0, `empty_o` 1, `mem_MemRead_o` 0, `mem_MemWrite_o` 0, `data_o` 0.

## Timing
- **Load latency:** 0 cycles (combinational through the block).
- **Store visibility:** a store is written to memory no earlier than the cycle after it is accepted, and in the first cycle with a free port.
- **Hazard stall (forwarding compiled out):** `stall_o` stays high until the last matching entry has popped. Because a stalled load does not issue, the port is free and the buffer drains every stall cycle. Worst case is DEPTH stall cycles.
- **Status outputs:** `stall_o` and `empty_o` are combinational from count, `addr_i` and the request inputs.

## Configuration
- **`STORE_BUFFER_FWD_EN` defined:**
  - A load that matches any valid entry takes the data of the youngest matching entry.
  - In that case `mem_MemRead_o` is 0 and `stall_o` is 0.
  - The drain proceeds the same cycle, because the port is free.
- **`STORE_BUFFER_FWD_EN` undefined:**
  - A load that matches any valid entry asserts `stall_o` and does not issue.
  - Otherwise loads behave the same as with the macro defined.

## Structure
- **Package `store_buffer_pkg`:** holds the entry struct (`valid`, word address, data) and the default DEPTH/ADDR_W/DATA_W constants.
- **Sub-module `store_buffer_match`:**
  - Compares the load word address against all entries.
  - Returns `hit`, `any_match` and the youngest matching data; "youngest" is relative to tail.
  - Instantiated regardless of the macro. Without the macro, only `any_match` is used.

## Test plan
- **Reset:** assert `rst_n_i` = 0 while 2 entries are pending, then release → `empty_o` = 1, `stall_o` = 0, and no `mem_MemWrite_o` pulse ever follows.
- **Single store:** `sw` 0x4←0x11, then idle → next cycle `mem_MemWrite_o` = 1, `mem_addr_o` = 0x4, `mem_data_o` = 0x11. `empty_o` = 1 after that edge.
- **Full:** 4 stores, then continuous loads to 0x100 while a 5th store is presented → `stall_o` = 1. Drop the loads for 1 cycle → one pop occurs and the 5th store is accepted the next cycle.
- **Load-after-store, forwarding compiled out:** `sw` 0x8←0xAA, then `lw` 0x8 next cycle → `stall_o` = 1 for 1 cycle, then `data_o` = 0xAA from memory.
- **Load-after-store, forwarding compiled in:** same sequence → `data_o` = 0xAA in the same cycle, `stall_o` = 0.
- **Youngest wins:** stores 0xC←0x1 then 0xC←0x2, both held in the buffer by loads to 0x100 → `lw` 0xC returns 0x2 (forwarding compiled in). Memory finally holds 0x2 at 0xC, written in order 0x1 then 0x2.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and default sizes for the store buffer.
// The entry struct widths follow the default ADDR_W/DATA_W below.
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-3:0] waddr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Associative lookup of a load word address against all buffered stores;
// reports any match and the data of the youngest match (relative to tail).
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              rd_i,
    input  logic [ADDR_W-3:0] waddr_i,
    input  sb_entry_t         entries_i [DEPTH],
    input  logic [PTR_W-1:0]  tail_i,
    output logic              hit_o,
    output logic              any_match_o,
    output logic [DATA_W-1:0] data_o
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); later matches overwrite.
    always_comb begin
        any_match_o = 1'b0;
        data_o      = '0;
        idx         = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail_i - PTR_W'(k);
            if (entries_i[idx].valid && (entries_i[idx].waddr == waddr_i)) begin
                any_match_o = 1'b1;
                data_o      = entries_i[idx].data;
            end
        end
    end

    assign hit_o = rd_i && any_match_o;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of the data memory: stores queue, loads own the port.
// Optional load forwarding from buffered stores: define STORE_BUFFER_FWD_EN.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              stall_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_MemRead_o,
    output logic              mem_MemWrite_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              full;
    logic              hit;
    logic              any_match;
    logic [DATA_W-1:0] fwd_data;
    logic              hazard;
    logic              load_issue;
    logic              push;
    logic              pop;
    sb_entry_t         push_entry;

    store_buffer_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_match (
        .rd_i        (MemRead_i),
        .waddr_i     (addr_i[ADDR_W-1:2]),
        .entries_i   (entries_q),
        .tail_i      (tail_q),
        .hit_o       (hit),
        .any_match_o (any_match),
        .data_o      (fwd_data)
    );

    assign full       = (count_q == CNT_W'(DEPTH));
    assign hazard     = MemRead_i && any_match;
    assign load_issue = MemRead_i && !hazard;
    assign pop        = (count_q != '0) && !load_issue;

`ifdef STORE_BUFFER_FWD_EN
    assign stall_o = MemWrite_i && full;
`else
    // A stalled MEM stage re-presents its store, so nothing is pushed while stalled.
    assign stall_o = (MemWrite_i && full) || hazard;
    logic unused_fwd;
    assign unused_fwd = ^{hit, fwd_data};
`endif

    assign push    = MemWrite_i && !stall_o;
    assign empty_o = (count_q == '0);

    assign push_entry = '{valid: 1'b1, waddr: addr_i[ADDR_W-1:2], data: data_i};

    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (pop) begin
                entries_q[head_q].valid <= 1'b0;
            end
            if (push) begin
                entries_q[tail_q] <= push_entry;
            end
        end
    end

    always_comb begin
        mem_MemRead_o  = load_issue;
        mem_MemWrite_o = pop;
        mem_addr_o     = '0;
        mem_data_o     = '0;
        data_o         = '0;
        if (load_issue) begin
            mem_addr_o = addr_i;
            data_o     = mem_data_i;
        end else if (pop) begin
            mem_addr_o = {entries_q[head_q].waddr, 2'b00};
            mem_data_o = entries_q[head_q].data;
        end
        if (pop) begin
            mem_data_o = entries_q[head_q].data;
        end
`ifdef STORE_BUFFER_FWD_EN
        if (hit) begin
            data_o = fwd_data;
        end
`endif
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer; a write monitor scores every memory write
// against the expected write queue and maintains a simple memory model.
module tb_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data_o;
    logic        stall;
    logic        empty;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    logic [63:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    store_buffer dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .MemRead_i      (MemRead),
        .MemWrite_i     (MemWrite),
        .addr_i         (addr),
        .data_i         (wdata),
        .data_o         (data_o),
        .stall_o        (stall),
        .empty_o        (empty),
        .mem_addr_o     (mem_addr),
        .mem_data_o     (mem_wdata),
        .mem_MemRead_o  (mem_rd),
        .mem_MemWrite_o (mem_wr),
        .mem_data_i     (mem_rdata)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_rd ? mem[mem_addr[9:2]] : 32'h0;

    // Write monitor / scoreboard
    always @(negedge clk) begin
        logic [63:0] exp;
        #2;
        if (mem_wr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                exp = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== exp) begin
                    errors++;
                    $display("FAIL write_order: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, exp[63:32], exp[31:0]);
                end
            end
            mem[mem_addr[9:2]] = mem_wdata;
        end
    end

    // Driver: apply one cycle of MEM-stage request, settle, return mid-cycle
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemRead  = rd;
        MemWrite = wr;
        addr     = a;
        wdata    = d;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b, required 1", empty); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, required 0", stall); end
        checks++; if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("FAIL reset_mem_en: got %b, required 00", {mem_rd, mem_wr}); end
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h, required 0", data_o); end
        // Two stores held in the buffer by concurrent loads
        drive(1'b1, 1'b1, 32'h20, 32'h55);
        checks++; if (data_o !== 32'hA500_0008) begin errors++; $display("FAIL reset_load_data: got %h, required a5000008", data_o); end
        drive(1'b1, 1'b1, 32'h24, 32'h66);
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b, required 0", mem_wr); end
        @(negedge clk);
        rst_n    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        #1;
        checks++; if ({empty, stall, mem_wr, mem_rd} !== 4'b1000) begin errors++; $display("FAIL reset_mid: got %b, required 1000", {empty, stall, mem_wr, mem_rd}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            checks++; if ({empty, stall} !== 2'b10) begin errors++; $display("FAIL reset_after: got %b, required 10", {empty, stall}); end
        end
    endtask

    task automatic test_single_store();
        exp_q.push_back({32'h4, 32'h11});
        drive(1'b0, 1'b1, 32'h4, 32'h11);
        checks++; if ({mem_wr, stall, empty} !== 3'b001) begin errors++; $display("FAIL ss_accept: got %b, required 001", {mem_wr, stall, empty}); end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL ss_wr: got %b, required 1", mem_wr); end
        checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL ss_addr: got %h, required 4", mem_addr); end
        checks++; if (mem_wdata !== 32'h11) begin errors++; $display("FAIL ss_data: got %h, required 11", mem_wdata); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL ss_pending: got %b, required 0", empty); end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if ({empty, mem_wr} !== 2'b10) begin errors++; $display("FAIL ss_drained: got %b, required 10", {empty, mem_wr}); end
    endtask

    task automatic test_full();
        int waited;
        for (int k = 0; k < 4; k++) exp_q.push_back({32'h40 + 32'(4 * k), 32'hB0 + 32'(k)});
        exp_q.push_back({32'h100, 32'hB4});
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'h40 + 32'(4 * k), 32'hB0 + 32'(k));
            checks++; if ({stall, mem_rd, mem_wr} !== 3'b010) begin errors++; $display("FAIL full_fill%0d: got %b, required 010", k, {stall, mem_rd, mem_wr}); end
        end
        checks++; if (data_o !== 32'hA500_0013) begin errors++; $display("FAIL full_load_data: got %h, required a5000013", data_o); end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 32'h100, 32'hB4);
            checks++; if ({stall, mem_rd, mem_wr} !== 3'b110) begin errors++; $display("FAIL full_stall%0d: got %b, required 110", k, {stall, mem_rd, mem_wr}); end
        end
        drive(1'b0, 1'b1, 32'h100, 32'hB4);
        checks++; if ({stall, mem_wr} !== 2'b11) begin errors++; $display("FAIL full_pop_stall: got %b, required 11", {stall, mem_wr}); end
        checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL full_pop_addr: got %h, required 40", mem_addr); end
        drive(1'b0, 1'b1, 32'h100, 32'hB4);
        checks++; if ({stall, mem_wr} !== 2'b01) begin errors++; $display("FAIL full_accept: got %b, required 01", {stall, mem_wr}); end
        waited = 0;
        do begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            waited++;
        end while (empty !== 1'b1 && waited < 10);
        checks++; if (waited !== 4) begin errors++; $display("FAIL full_drain_cycles: got %0d, required 4", waited); end
    endtask

    task automatic test_load_after_store();
        exp_q.push_back({32'h8, 32'hAA});
        drive(1'b0, 1'b1, 32'h8, 32'hAA);
        drive(1'b1, 1'b0, 32'h8, 32'h0);
`ifdef STORE_BUFFER_FWD_EN
        checks++; if ({stall, mem_rd, mem_wr} !== 3'b001) begin errors++; $display("FAIL las_fwd_ctl: got %b, required 001", {stall, mem_rd, mem_wr}); end
        checks++; if (data_o !== 32'hAA) begin errors++; $display("FAIL las_fwd_data: got %h, required aa", data_o); end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
`else
        checks++; if ({stall, mem_rd, mem_wr} !== 3'b101) begin errors++; $display("FAIL las_stall: got %b, required 101", {stall, mem_rd, mem_wr}); end
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL las_stall_data: got %h, required 0", data_o); end
        drive(1'b1, 1'b0, 32'h8, 32'h0);
        checks++; if ({stall, mem_rd} !== 2'b01) begin errors++; $display("FAIL las_issue: got %b, required 01", {stall, mem_rd}); end
        checks++; if (data_o !== 32'hAA) begin errors++; $display("FAIL las_mem_data: got %h, required aa", data_o); end
`endif
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL las_empty: got %b, required 1", empty); end
    endtask

    task automatic test_youngest();
        exp_q.push_back({32'h80, 32'h77});
        exp_q.push_back({32'hC, 32'h1});
        exp_q.push_back({32'hC, 32'h2});
        drive(1'b1, 1'b1, 32'h80, 32'h77);
        drive(1'b1, 1'b1, 32'hC, 32'h1);
        drive(1'b1, 1'b0, 32'h100, 32'h0);
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL yw_hold: got %b, required 0", mem_wr); end
        drive(1'b0, 1'b1, 32'hC, 32'h2);
        checks++; if ({stall, mem_wr, mem_addr} !== {2'b01, 32'h80}) begin errors++; $display("FAIL yw_push2: got %b/%h, required 01/80", {stall, mem_wr}, mem_addr); end
        drive(1'b1, 1'b0, 32'hC, 32'h0);
`ifdef STORE_BUFFER_FWD_EN
        checks++; if ({stall, mem_rd, mem_wr} !== 3'b001) begin errors++; $display("FAIL yw_fwd_ctl: got %b, required 001", {stall, mem_rd, mem_wr}); end
        checks++; if (data_o !== 32'h2) begin errors++; $display("FAIL yw_fwd_data: got %h, required 2", data_o); end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
`else
        checks++; if ({stall, mem_rd} !== 2'b10) begin errors++; $display("FAIL yw_stall1: got %b, required 10", {stall, mem_rd}); end
        drive(1'b1, 1'b0, 32'hC, 32'h0);
        checks++; if ({stall, mem_rd} !== 2'b10) begin errors++; $display("FAIL yw_stall2: got %b, required 10", {stall, mem_rd}); end
        drive(1'b1, 1'b0, 32'hC, 32'h0);
        checks++; if ({stall, mem_rd} !== 2'b01) begin errors++; $display("FAIL yw_issue: got %b, required 01", {stall, mem_rd}); end
        checks++; if (data_o !== 32'h2) begin errors++; $display("FAIL yw_mem_data: got %h, required 2", data_o); end
`endif
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL yw_empty: got %b, required 1", empty); end
        checks++; if (mem[3] !== 32'h2) begin errors++; $display("FAIL yw_mem_final: got %h, required 2", mem[3]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);
        rst_n    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_single_store();
        test_full();
        test_load_after_store();
        test_youngest();

        repeat (4) drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
